io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter TX_DEPTH, default 8, sets TX FIFO entries; power of two, minimum 4.
REQ-002 Parameter FULL_MARGIN, default 2, sets the free-entry threshold for io_buffer_full.
REQ-003 clk_in  in  1  single clock, all state on rising edge.
REQ-004 rst_in  in  1  asynchronous, active-low reset.
REQ-005 rdy_in  in  1  CPU-side access enable; low freezes CPU-side effects.
REQ-006 cpu_a  in  32  CPU byte address; only [17:0] decoded.
REQ-007 cpu_dout  in  8  write byte from CPU.
REQ-008 cpu_wr  in  1  1 = write, 0 = read.
REQ-009 cpu_din  out  8  read byte to CPU, valid the cycle after the read.
REQ-010 io_buffer_full  out  1  TX FIFO near-full back-pressure to CPU.
REQ-011 ram_en, ram_wr  out  1 each  RAM strobe and write.
REQ-012 ram_a  out  17  RAM byte address.
REQ-013 ram_dout  out  8  RAM write byte.
REQ-014 ram_din  in  8  RAM read byte, 1-cycle synchronous latency.
REQ-015 tx_data  out  8 / tx_valid  out  1 / tx_ready  in  1  UART TX valid/ready stream.
REQ-016 rx_data  in  8 / rx_valid  in  1 / rx_ready  out  1  UART RX stream.
REQ-017 program_done  out  1  sticky program-stop flag.
REQ-018 tx_overflow  out  1  sticky, set when a push is dropped because the FIFO is full.

Function
REQ-019 Decode: IO when cpu_a[17:16]==2'b11, otherwise RAM.
REQ-020 RAM path is combinational: ram_en=rdy_in&~IO, ram_wr=cpu_wr, ram_a=cpu_a[16:0], ram_dout=cpu_dout.
REQ-021 A registered source select records the read type for the following cycle; cpu_din=ram_din after a RAM read, else the registered IO read byte.
REQ-022 Read 0x30000 with rx_valid=1: rx_ready=1 that cycle (pop), return rx_data next cycle; with rx_valid=0: no pop, return 0x00.
REQ-023 rx_ready is asserted only for a qualifying 0x30000 read with rdy_in=1.
REQ-024 32-bit cycle counter: cleared by reset, +1 every clock regardless of rdy_in, wraps 0xFFFFFFFF->0.
REQ-025 Read 0x30004 captures the counter into a snapshot register and returns byte0; reads 0x30005-0x30007 return snapshot bytes 1-3 (little-endian) without recapture.
REQ-026 Write 0x30000 with nonzero byte pushes it into the TX FIFO; a 0x00 write is ignored.
REQ-027 Write 0x30004 pushes 0x00 into the TX FIFO and sets program_done on the next edge.
REQ-028 Other IO addresses: writes ignored; reads return 0x00.
REQ-029 TX FIFO: tx_valid=(count!=0), tx_data=head entry; pop on tx_valid&tx_ready.
REQ-030 Push and pop in the same cycle: both occur, count unchanged, including when count==TX_DEPTH.
REQ-031 Push at count==TX_DEPTH without a simultaneous pop: byte dropped, tx_overflow set.
REQ-032 Pointers wrap modulo TX_DEPTH; count width is log2(TX_DEPTH)+1.
REQ-033 io_buffer_full = (count >= TX_DEPTH-FULL_MARGIN), registered from the post-update count.
REQ-034 rdy_in=0: no RAM strobe, no FIFO push, no RX pop, no snapshot capture; cpu_din and the source select hold; TX drain and counter continue.

Reset
REQ-035 On rst_in low, immediately: FIFO empty, tx_valid=0, cpu_din=0x00, io_buffer_full=0, program_done=0, tx_overflow=0, counter=0, snapshot=0, rx_ready=0.
REQ-036 Reset mid-operation discards FIFO contents and any pending read result; the first cycle after release is a normal access cycle.

Verification
REQ-037 RAM write 0x1234<-0xAB then read 0x1234 -> ram_en pulses; cpu_din=0xAB one cycle after the read.
REQ-038 Tx_ready=0, write 0x41 to 0x30000 six times (DEPTH 8) -> io_buffer_full=1 after the 6th; 7th-8th accepted; 9th dropped and tx_overflow=1.
REQ-039 FIFO full with tx_ready=1 and a simultaneous push -> count stays 8; output order is preserved FIFO order.
REQ-040 Reads 0x30004-0x30007 in consecutive cycles -> the four bytes reconstruct the counter value at the 0x30004 read, not later values.
REQ-041 Read 0x30000 with rx_valid=0 -> cpu_din=0x00 and rx_ready=0; with rx_valid=1, rx_data=0x5A -> one rx_ready pulse, cpu_din=0x5A.
REQ-042 Write 0x30004 while rdy_in=0 -> nothing happens; repeat with rdy_in=1 -> 0x00 emitted on TX and program_done=1; assert rst_in low -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/io_bridge.sv
// CPU-side memory/IO bridge: routes accesses to RAM or to a small IO block with a UART TX FIFO,
// UART RX pop port, free-running cycle counter with byte-wise snapshot reads, and a stop flag.
module io_bridge #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int unsigned PtrW = $clog2(TX_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(TX_DEPTH);
  localparam logic [CntW-1:0] FullThr = CntW'(TX_DEPTH - FULL_MARGIN);

  logic        is_io;
  logic [15:0] io_off;
  logic        io_rd;
  logic        io_wr;
  logic        unused_addr;

  assign is_io       = (cpu_a[17:16] == 2'b11);
  assign io_off      = cpu_a[15:0];
  assign io_rd       = rdy_in & is_io & ~cpu_wr;
  assign io_wr       = rdy_in & is_io & cpu_wr;
  assign unused_addr = ^cpu_a[31:18];

  assign ram_en   = rdy_in & ~is_io;
  assign ram_wr   = cpu_wr;
  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;

  // Gated by reset so the RX source never sees a pop while the bridge is held in reset.
  assign rx_ready = rst_in & io_rd & (io_off == 16'h0000) & rx_valid;

  logic [31:0] cycle_q;
  logic [31:0] snap_q;
  logic [31:0] snap_d;
  logic        src_ram_q;
  logic [7:0]  rdata_q;
  logic [7:0]  io_rdata;

  always_comb begin
    io_rdata = 8'h00;
    snap_d   = snap_q;
    if (io_rd) begin
      case (io_off)
        16'h0000: io_rdata = rx_valid ? rx_data : 8'h00;
        16'h0004: begin
          io_rdata = cycle_q[7:0];
          snap_d   = cycle_q;
        end
        16'h0005: io_rdata = snap_q[15:8];
        16'h0006: io_rdata = snap_q[23:16];
        16'h0007: io_rdata = snap_q[31:24];
        default:  io_rdata = 8'h00;
      endcase
    end
  end

  assign cpu_din = src_ram_q ? ram_din : rdata_q;

  logic [7:0]      mem_q [TX_DEPTH];
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] rd_ptr_d;
  logic            push_req;
  logic [7:0]      push_data;
  logic            push;
  logic            pop;
  logic            drop;
  logic            stop_wr;
  logic            full_q;
  logic            done_q;
  logic            ovf_q;

  assign stop_wr   = io_wr & (io_off == 16'h0004);
  assign push_req  = (io_wr & (io_off == 16'h0000) & (cpu_dout != 8'h00)) | stop_wr;
  assign push_data = stop_wr ? 8'h00 : cpu_dout;
  assign tx_valid  = (count_q != '0);
  assign tx_data   = mem_q[rd_ptr_q];
  assign pop       = tx_valid & tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req & ((count_q != DepthC) | pop);
  assign drop      = push_req & ~push;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_q   <= '0;
      snap_q    <= '0;
      src_ram_q <= 1'b0;
      rdata_q   <= 8'h00;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (rdy_in) begin
        src_ram_q <= ~is_io & ~cpu_wr;
        rdata_q   <= io_rdata;
        snap_q    <= snap_d;
      end
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (count_d >= FullThr);
      done_q   <= done_q | stop_wr;
      ovf_q    <= ovf_q | drop;
    end
  end

  assign io_buffer_full = full_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_io_bridge.sv
// Testbench for io_bridge: directed scenarios plus a randomized run checked against a
// queue-based model of the bridge's IO behaviour and a behavioural RAM.
module tb_io_bridge;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic        ram_en;
  logic        ram_wr;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_done;
  logic        tx_overflow;

  int errors = 0;
  int checks = 0;

  io_bridge #(.TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full), .ram_en(ram_en),
    .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .program_done(program_done),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Synchronous RAM device with one cycle of read latency.
  bit [7:0] fx_mem [0:131071];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) fx_mem[ram_a] <= ram_dout;
      else ram_din <= fx_mem[ram_a];
    end
  end

  // Reference model, evaluated mid-cycle on the inputs the next rising edge will see.
  logic [7:0]  m_q [$];
  bit          m_full, m_ovf, m_done, m_din_known, m_io, m_pop, m_push;
  logic [7:0]  m_din, m_pd;
  logic [31:0] m_cnt, m_snap;
  int unsigned m_off;
  bit [7:0]    ref_mem [0:131071];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_full = 0; m_ovf = 0; m_done = 0;
      m_cnt = '0; m_snap = '0; m_din = 8'h00; m_din_known = 1;
    end else begin
      m_io   = (cpu_a[17:16] == 2'b11);
      m_off  = {16'h0000, cpu_a[15:0]};
      m_pop  = (m_q.size() != 0) && tx_ready;
      m_push = 0;
      m_pd   = 8'h00;
      if (m_pop) void'(m_q.pop_front());
      if (rdy) begin
        if (!m_io) begin
          if (cpu_wr) begin
            ref_mem[cpu_a[16:0]] = cpu_dout;
            m_din_known = 0;
          end else begin
            m_din = ref_mem[cpu_a[16:0]];
            m_din_known = 1;
          end
        end else if (cpu_wr) begin
          m_din_known = 0;
          if (m_off == 0 && cpu_dout != 8'h00) begin
            m_push = 1; m_pd = cpu_dout;
          end else if (m_off == 4) begin
            m_push = 1; m_pd = 8'h00; m_done = 1;
          end
        end else begin
          m_din_known = 1;
          m_din = 8'h00;
          if (m_off == 0 && rx_valid) m_din = rx_data;
          else if (m_off == 4) begin
            m_snap = m_cnt;
            m_din = m_cnt[7:0];
          end else if (m_off >= 5 && m_off <= 7) m_din = 8'(m_snap >> (8 * (m_off - 4)));
        end
      end
      if (m_push) begin
        if (m_q.size() < int'(DEPTH)) m_q.push_back(m_pd);
        else m_ovf = 1;
      end
      m_full = (m_q.size() >= int'(DEPTH - MARGIN));
      m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic r);
    cpu_a = a; cpu_wr = wr; cpu_dout = d; rdy = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rx_valid = 1'b1; rx_data = 8'h33;
    drive(32'h0003_0000, 1'b0, 8'h00, 1'b1);
    #2;
    checks++;
    if ({tx_valid, io_buffer_full, program_done, tx_overflow, rx_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=00000",
               {tx_valid, io_buffer_full, program_done, tx_overflow, rx_ready});
    end
    checks++;
    if (cpu_din !== 8'h00) begin
      errors++; $display("FAIL reset_cpu_din got=%h want=00", cpu_din);
    end
    rx_valid = 1'b0;
    drive(32'h0, 1'b0, 8'h00, 1'b0);
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_ram;
    tx_ready = 1'b1;
    drive(32'h0000_1234, 1'b1, 8'hAB, 1'b1);
    #1;
    checks++;
    if ({ram_en, ram_wr, ram_a, ram_dout} !== {1'b1, 1'b1, 17'h01234, 8'hAB}) begin
      errors++;
      $display("FAIL ram_write_strobe got=%b/%b/%h/%h want=1/1/01234/ab",
               ram_en, ram_wr, ram_a, ram_dout);
    end
    tick;
    drive(32'h0000_1234, 1'b0, 8'h00, 1'b1);
    #1;
    checks++;
    if ({ram_en, ram_wr} !== 2'b10) begin
      errors++; $display("FAIL ram_read_strobe got=%b%b want=10", ram_en, ram_wr);
    end
    tick;
    drive(32'h0, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (cpu_din !== 8'hAB) begin
      errors++; $display("FAIL ram_read_data got=%h want=ab", cpu_din);
    end
    checks++;
    if (ram_en !== 1'b0) begin
      errors++; $display("FAIL ram_en_no_rdy got=%b want=0", ram_en);
    end
  endtask

  task automatic test_fifo_fill;
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL fill_start_empty got=%b want=0", tx_valid);
    end
    for (int i = 1; i <= 9; i++) begin
      drive(32'h0003_0000, 1'b1, 8'(8'h40 + i), 1'b1);
      tick;
      #1;
      checks++;
      if (io_buffer_full !== (i >= 6)) begin
        errors++; $display("FAIL fill_full_%0d got=%b want=%b", i, io_buffer_full, (i >= 6));
      end
      checks++;
      if (tx_overflow !== (i >= 9)) begin
        errors++; $display("FAIL fill_overflow_%0d got=%b want=%b", i, tx_overflow, (i >= 9));
      end
    end
    drive(32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp [$];
    int n;
    for (int i = 1; i <= 8; i++) exp.push_back(8'(8'h40 + i));
    tx_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(32'h0003_0000, 1'b1, 8'(8'h50 + j), 1'b1);
      #1;
      checks++;
      if (tx_data !== exp[0] || tx_valid !== 1'b1) begin
        errors++; $display("FAIL pushpop_head_%0d got=%h want=%h", j, tx_data, exp[0]);
      end
      void'(exp.pop_front());
      exp.push_back(8'(8'h50 + j));
      tick;
      #1;
    end
    drive(32'h0, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (tx_valid === 1'b1 && n < 20) begin
      checks++;
      if (exp.size() == 0 || tx_data !== exp[0]) begin
        errors++; $display("FAIL drain_order_%0d got=%h want=%h", n, tx_data,
                           (exp.size() != 0) ? exp[0] : 8'hxx);
      end
      if (exp.size() != 0) void'(exp.pop_front());
      n++;
      tick;
      #1;
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL drain_count got=%0d want=8", n);
    end
    checks++;
    if (io_buffer_full !== 1'b0) begin
      errors++; $display("FAIL drain_full_clear got=%b want=0", io_buffer_full);
    end
  endtask

  task automatic test_snapshot;
    logic [31:0] exp_cnt;
    logic [7:0]  b [4];
    drive(32'h0003_0004, 1'b0, 8'h00, 1'b1);
    exp_cnt = m_cnt;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k < 3) drive(32'h0003_0005 + k, 1'b0, 8'h00, 1'b1);
      else drive(32'h0, 1'b0, 8'h00, 1'b0);
      #1;
      b[k] = cpu_din;
    end
    checks++;
    if ({b[3], b[2], b[1], b[0]} !== exp_cnt) begin
      errors++; $display("FAIL snapshot_value got=%h want=%h", {b[3], b[2], b[1], b[0]}, exp_cnt);
    end
    repeat (300) tick;
    drive(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    tick;
    drive(32'h0003_0005, 1'b0, 8'h00, 1'b1);
    tick;
    drive(32'h0, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (cpu_din !== exp_cnt[15:8]) begin
      errors++; $display("FAIL snapshot_no_rdy got=%h want=%h", cpu_din, exp_cnt[15:8]);
    end
  endtask

  task automatic test_rx;
    rx_valid = 1'b0; rx_data = 8'h5A;
    drive(32'h0003_0000, 1'b0, 8'h00, 1'b1);
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL rx_empty_ready got=%b want=0", rx_ready);
    end
    tick;
    rx_valid = 1'b1;
    drive(32'h0003_0000, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (cpu_din !== 8'h00 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL rx_empty_data got=%h/%b want=00/0", cpu_din, rx_ready);
    end
    drive(32'h0003_0000, 1'b0, 8'h00, 1'b1);
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL rx_pop_ready got=%b want=1", rx_ready);
    end
    tick;
    rx_valid = 1'b0;
    drive(32'h0, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (cpu_din !== 8'h5A || rx_ready !== 1'b0) begin
      errors++; $display("FAIL rx_pop_data got=%h/%b want=5a/0", cpu_din, rx_ready);
    end
  endtask

  task automatic test_program_done;
    tx_ready = 1'b0;
    drive(32'h0003_0004, 1'b1, 8'h77, 1'b0);
    tick;
    #1;
    checks++;
    if (program_done !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL stop_no_rdy got=%b/%b want=0/0", program_done, tx_valid);
    end
    drive(32'h0003_0004, 1'b1, 8'h77, 1'b1);
    tick;
    drive(32'h0, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (program_done !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL stop_write got=%b/%b/%h want=1/1/00", program_done, tx_valid, tx_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, io_buffer_full, program_done, tx_overflow} !== 4'b0 || cpu_din !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%b%b%b%b/%h want=0000/00", tx_valid, io_buffer_full,
               program_done, tx_overflow, cpu_din);
    end
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [15:0] offs [9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0005, 16'h0006,
                              16'h0007, 16'h0008, 16'h0100};
    logic [31:0] a;
    logic        exp_rx;
    for (int c = 0; c < 500; c++) begin
      a = $urandom;
      if ($urandom_range(0, 9) < 3) begin
        a[17:16] = 2'($urandom_range(0, 2));
        a[15:4]  = 12'h123;
      end else begin
        a[17:16] = 2'b11;
        a[15:0]  = offs[$urandom_range(0, 8)];
      end
      drive(a, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), ($urandom_range(0, 4) != 0));
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      #1;
      exp_rx = rdy && a[17:16] == 2'b11 && !cpu_wr && a[15:0] == 16'h0000 && rx_valid;
      checks++;
      if (rx_ready !== exp_rx || ram_en !== (rdy && a[17:16] != 2'b11)) begin
        errors++;
        $display("FAIL rand_strobes_%0d got=%b%b want=%b%b", c, rx_ready, ram_en, exp_rx,
                 (rdy && a[17:16] != 2'b11));
      end
      tick;
      checks++;
      if (tx_valid !== (m_q.size() != 0) || (m_q.size() != 0 && tx_data !== m_q[0])) begin
        errors++;
        $display("FAIL rand_tx_%0d got=%b/%h want=%b/%h", c, tx_valid, tx_data,
                 (m_q.size() != 0), (m_q.size() != 0) ? m_q[0] : 8'hxx);
      end
      checks++;
      if ({io_buffer_full, tx_overflow, program_done} !== {m_full, m_ovf, m_done}) begin
        errors++;
        $display("FAIL rand_flags_%0d got=%b%b%b want=%b%b%b", c, io_buffer_full, tx_overflow,
                 program_done, m_full, m_ovf, m_done);
      end
      if (m_din_known) begin
        checks++;
        if (cpu_din !== m_din) begin
          errors++; $display("FAIL rand_cpu_din_%0d got=%h want=%h", c, cpu_din, m_din);
        end
      end
    end
    drive(32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete got=running want=finished");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_ram;
    test_fifo_fill;
    test_full_push_pop;
    test_snapshot;
    test_rx;
    test_program_done;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
